multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Multi-cycle control FSM for the RV32I-subset core. Sequences fetch/decode/execute/memory/writeback
//  over the shared ALU, register file and single unified memory port. Reads the latched instruction
//  register and drives every datapath mux select, write enable, ALU op and memory handshake.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles mem_req may wait for mem_ready before abort; 0 = wait forever
//  CNT_W         5  width of wait counter; must hold MEM_TIMEOUT
// PORTS
//  clk        in   1   core clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  instr      in   32  instruction register contents (valid from DECODE onward)
//  mem_ready  in   1   memory completes current request this cycle
//  zero       in   1   ALU zero flag (valid in EXECUTE of a branch)
//  pc_we      out  1   PC register write enable
//  ir_we      out  1   instruction register write enable
//  rf_we      out  1   register file write enable
//  mem_req    out  1   memory request, held until mem_ready or abort
//  mem_we     out  1   memory write (qualifies mem_req)
//  addr_sel   out  1   memory address: 0 = PC, 1 = ALU result register
//  a_sel      out  1   ALU A: 0 = PC, 1 = rs1
//  b_sel      out  2   ALU B: 0 = rs2, 1 = const 4, 2 = imm_i/imm_s, 3 = imm_b
//  alu_op     out  3   0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLL,7 SRL
//  mtr_sel    out  1   writeback source: 0 = ALU result, 1 = memory data
//  branch_sel out  1   PC source: 0 = ALU output, 1 = ALU result register (branch target)
//  state      out  3   current state encoding (debug)
//  timeout    out  1   one-cycle pulse on memory abort
//  trap       out  1   sticky illegal-instruction flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=FETCH, wait counter=0, trap=0; all enables, selects, alu_op, timeout = 0.
//  - All outputs decoded from registered state + instr; state advances on rising clk only.
//  - States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=7.
//  - FETCH: mem_req=1, addr_sel=0, a_sel=0, b_sel=1, alu_op=ADD. On mem_ready: ir_we=1, pc_we=1,
//    branch_sel=0 (PC<=PC+4), ->DECODE. Else hold.
//  - DECODE: a_sel=0, b_sel=3, alu_op=ADD (precomputes PC_old+imm_b into result register; datapath
//    compensates PC+4 offset). Opcode instr[6:0]: 0110011 R, 0010011 I, 0000011 LOAD,
//    0100011 STORE, 1100011 BRANCH -> EXEC; any other -> illegal handling.
//  - EXEC: a_sel=1. R: b_sel=0; I: b_sel=2. alu_op from funct3 {000 ADD/SUB (SUB iff R and
//    instr[30]), 111 AND, 110 OR, 100 XOR, 010 SLT, 001 SLL, 101 SRL}; ->WB. LOAD/STORE: b_sel=2,
//    ADD, ->MEM. BRANCH: b_sel=0, SUB; funct3 000 BEQ takes if zero, 001 BNE if !zero, others
//    never taken; taken -> pc_we=1, branch_sel=1; ->FETCH.
//  - MEM: mem_req=1, addr_sel=1, mem_we=1 iff STORE. On mem_ready: STORE ->FETCH, LOAD ->WB.
//  - WB: rf_we=1, mtr_sel=1 iff LOAD; ->FETCH. Writes to rd=0 still asserted; regfile ignores.
//  - Latency (mem_ready same cycle as request): R/I 4, LOAD 5, STORE 4, BRANCH 3 cycles.
//  - Wait counter: cleared on entry to FETCH/MEM, increments each cycle mem_req=1 && !mem_ready.
//    When MEM_TIMEOUT!=0 and counter reaches MEM_TIMEOUT-1 without mem_ready: timeout=1 for that
//    cycle, no write enables, ->FETCH (PC unchanged; STORE/LOAD dropped). mem_ready on that same
//    cycle wins: normal completion, no timeout.
//  - Reset asserted mid-instruction: immediate return to FETCH, in-flight request dropped.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined: illegal opcode in DECODE -> TRAP; trap=1, all enables 0, held until rst.
//  Undefined: illegal opcode treated as NOP, DECODE ->FETCH; trap tied 0; TRAP state unreachable.
// TESTING
//  - Reset then release, mem_ready=1 constant -> FETCH with mem_req=1, addr_sel=0; ir_we,pc_we at cycle 1.
//  - instr=0x40208033 (sub x0,x1,x2), mem_ready=1 -> EXEC alu_op=1,b_sel=0; WB rf_we=1; 4 cycles.
//  - instr=0x0000A103 (lw) with mem_ready delayed 3 cycles in MEM -> mem_req held, mem_we=0, WB mtr_sel=1.
//  - instr=0x00208463 (beq) zero=1 -> EXEC pc_we=1,branch_sel=1; zero=0 -> pc_we=0; both back to FETCH.
//  - mem_ready held 0 in FETCH, MEM_TIMEOUT=16 -> timeout pulse on 16th cycle, ir_we never set, FETCH.
//  - instr=0xFFFFFFFF: ILLEGAL_TRAP_EN -> state=7, trap=1 until rst; without -> FETCH, trap=0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I-subset control FSM: fetch/decode/exec/mem/wb sequencing with memory wait timeout.
// Optional macro ILLEGAL_TRAP_EN: illegal opcodes park the FSM in TRAP (sticky) instead of acting as NOP.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        zero,
  output logic        pc_we,
  output logic        ir_we,
  output logic        rf_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        a_sel,
  output logic [1:0]  b_sel,
  output logic [2:0]  alu_op,
  output logic        mtr_sel,
  output logic        branch_sel,
  output logic [2:0]  state,
  output logic        timeout,
  output logic        trap
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, TRAP = 3'd7
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                         OP_XOR = 3'd4, OP_SLT = 3'd5, OP_SLL = 3'd6, OP_SRL = 3'd7;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           st_q, st_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3;
  logic             is_r, is_i, is_ld, is_st, is_br, legal, br_taken;
  logic             unused_instr;

  assign f3       = instr[14:12];
  assign is_r     = instr[6:0] == 7'b0110011;
  assign is_i     = instr[6:0] == 7'b0010011;
  assign is_ld    = instr[6:0] == 7'b0000011;
  assign is_st    = instr[6:0] == 7'b0100011;
  assign is_br    = instr[6:0] == 7'b1100011;
  assign legal    = is_r | is_i | is_ld | is_st | is_br;
  assign br_taken = (f3 == 3'b000 && zero) || (f3 == 3'b001 && !zero);
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};
  assign state    = st_q;

  function automatic logic [2:0] f3_op(input logic [2:0] fn, input logic sub);
    case (fn)
      3'b000:  f3_op = sub ? OP_SUB : OP_ADD;
      3'b111:  f3_op = OP_AND;
      3'b110:  f3_op = OP_OR;
      3'b100:  f3_op = OP_XOR;
      3'b010:  f3_op = OP_SLT;
      3'b001:  f3_op = OP_SLL;
      3'b101:  f3_op = OP_SRL;
      default: f3_op = OP_ADD;
    endcase
  endfunction

  always_comb begin
    st_d       = st_q;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    rf_we      = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    a_sel      = 1'b0;
    b_sel      = 2'd0;
    alu_op     = OP_ADD;
    mtr_sel    = 1'b0;
    branch_sel = 1'b0;
    timeout    = 1'b0;
    // Everything reads zero while reset is held, including the FETCH selects.
    if (!rst) begin
      case (st_q)
        FETCH: begin
          mem_req = 1'b1;
          b_sel   = 2'd1;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
            st_d  = DECODE;
          end
        end
        DECODE: begin
          b_sel = 2'd3;
          if (legal) st_d = EXEC;
`ifdef ILLEGAL_TRAP_EN
          else       st_d = TRAP;
`else
          else       st_d = FETCH;
`endif
        end
        EXEC: begin
          a_sel = 1'b1;
          st_d  = FETCH;
          if (is_r) begin
            alu_op = f3_op(f3, instr[30]);
            st_d   = WB;
          end else if (is_i) begin
            b_sel  = 2'd2;
            alu_op = f3_op(f3, 1'b0);
            st_d   = WB;
          end else if (is_ld || is_st) begin
            b_sel = 2'd2;
            st_d  = MEM;
          end else if (is_br) begin
            alu_op = OP_SUB;
            if (br_taken) begin
              pc_we      = 1'b1;
              branch_sel = 1'b1;
            end
          end
        end
        MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = is_st;
          if (mem_ready) st_d = is_st ? FETCH : WB;
        end
        WB: begin
          rf_we   = 1'b1;
          mtr_sel = is_ld;
          st_d    = FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        TRAP:    st_d = TRAP;
`endif
        default: st_d = FETCH;
      endcase
      // Abort only fires while still waiting; a same-cycle mem_ready completes normally.
      if (MEM_TIMEOUT != 0 && mem_req && !mem_ready && cnt_q == TO_LAST) begin
        timeout = 1'b1;
        st_d    = FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= FETCH;
      cnt_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_d != st_q || timeout) cnt_q <= '0;
      else if (mem_req && !mem_ready) cnt_q <= cnt_q + 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign trap = (st_q == TRAP);
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected output vectors are queued as stimulus is driven.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        mem_ready, zero;
  logic        pc_we, ir_we, rf_we, mem_req, mem_we, addr_sel, a_sel, mtr_sel, branch_sel;
  logic        timeout, trap;
  logic [1:0]  b_sel;
  logic [2:0]  alu_op, state;

  typedef struct packed {
    logic [2:0] st;
    logic       pc_we, ir_we, rf_we, mem_req, mem_we, addr_sel, a_sel;
    logic [1:0] b_sel;
    logic [2:0] alu_op;
    logic       mtr_sel, branch_sel, timeout, trap;
  } obs_t;

  obs_t exp_q[$];
  obs_t act;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .zero(zero),
    .pc_we(pc_we), .ir_we(ir_we), .rf_we(rf_we), .mem_req(mem_req), .mem_we(mem_we),
    .addr_sel(addr_sel), .a_sel(a_sel), .b_sel(b_sel), .alu_op(alu_op), .mtr_sel(mtr_sel),
    .branch_sel(branch_sel), .state(state), .timeout(timeout), .trap(trap)
  );

  assign act = {state, pc_we, ir_we, rf_we, mem_req, mem_we, addr_sel, a_sel, b_sel, alu_op,
                mtr_sel, branch_sel, timeout, trap};

  task automatic chk(input string tag, input obs_t got, input obs_t want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (st/pc/ir/rf/req/we/asel/a/b/alu/mtr/br/to/trap)",
               tag, got, want);
    end
  endtask

  function automatic obs_t o(input logic [2:0] st);
    obs_t r = '0;
    r.st = st;
    return r;
  endfunction

  function automatic obs_t f_fetch(input logic rdy);
    obs_t r = o(3'd0);
    r.mem_req = 1'b1; r.b_sel = 2'd1; r.ir_we = rdy; r.pc_we = rdy;
    return r;
  endfunction

  function automatic obs_t f_dec();
    obs_t r = o(3'd1);
    r.b_sel = 2'd3;
    return r;
  endfunction

  function automatic obs_t f_exec(input logic [1:0] b, input logic [2:0] op, input logic tk);
    obs_t r = o(3'd2);
    r.a_sel = 1'b1; r.b_sel = b; r.alu_op = op; r.pc_we = tk; r.branch_sel = tk;
    return r;
  endfunction

  function automatic obs_t f_mem(input logic we);
    obs_t r = o(3'd3);
    r.mem_req = 1'b1; r.addr_sel = 1'b1; r.mem_we = we;
    return r;
  endfunction

  function automatic obs_t f_wb(input logic mtr);
    obs_t r = o(3'd4);
    r.rf_we = 1'b1; r.mtr_sel = mtr;
    return r;
  endfunction

  function automatic obs_t with_to(input obs_t e);
    obs_t r = e;
    r.timeout = 1'b1;
    return r;
  endfunction

  // Drive one cycle of inputs (just after posedge), compare at negedge.
  task automatic cyc(input string tag, input logic rdy, input logic z, input obs_t e);
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(e);
    @(negedge clk);
    chk(tag, act, exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t t;
    rst = 1'b1; instr = 32'h0; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    cyc("reset", 1'b1, 1'b0, o(3'd0));
    rst = 1'b0;

    // sub x0,x1,x2
    instr = 32'h40208033;
    cyc("sub_fetch", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("sub_dec",   1'b1, 1'b0, f_dec());
    cyc("sub_exec",  1'b1, 1'b0, f_exec(2'd0, 3'd1, 1'b0));
    cyc("sub_wb",    1'b1, 1'b0, f_wb(1'b0));

    // xori x1,x2,4 and slt x1,x1,x2
    instr = 32'h00414093;
    cyc("xori_fetch", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("xori_dec",   1'b1, 1'b0, f_dec());
    cyc("xori_exec",  1'b1, 1'b0, f_exec(2'd2, 3'd4, 1'b0));
    cyc("xori_wb",    1'b1, 1'b0, f_wb(1'b0));
    instr = 32'h0020A0B3;
    cyc("slt_fetch", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("slt_dec",   1'b1, 1'b0, f_dec());
    cyc("slt_exec",  1'b1, 1'b0, f_exec(2'd0, 3'd5, 1'b0));
    cyc("slt_wb",    1'b1, 1'b0, f_wb(1'b0));

    // lw with memory ready three cycles late
    instr = 32'h0000A103;
    cyc("lw_fetch", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("lw_dec",   1'b1, 1'b0, f_dec());
    cyc("lw_exec",  1'b1, 1'b0, f_exec(2'd2, 3'd0, 1'b0));
    for (int i = 0; i < 3; i++) cyc("lw_memwait", 1'b0, 1'b0, f_mem(1'b0));
    cyc("lw_memdone", 1'b1, 1'b0, f_mem(1'b0));
    cyc("lw_wb",      1'b1, 1'b0, f_wb(1'b1));

    // beq taken / not taken, bne taken
    instr = 32'h00208463;
    cyc("beq1_fetch", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("beq1_dec",   1'b1, 1'b0, f_dec());
    cyc("beq1_exec",  1'b1, 1'b1, f_exec(2'd0, 3'd1, 1'b1));
    cyc("beq0_fetch", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("beq0_dec",   1'b1, 1'b0, f_dec());
    cyc("beq0_exec",  1'b1, 1'b0, f_exec(2'd0, 3'd1, 1'b0));
    instr = 32'h00209463;
    cyc("bne_fetch", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("bne_dec",   1'b1, 1'b0, f_dec());
    cyc("bne_exec",  1'b1, 1'b0, f_exec(2'd0, 3'd1, 1'b1));

    // sw whose fetch completes exactly on the would-be timeout cycle
    instr = 32'h0020A023;
    for (int i = 0; i < 15; i++) cyc("sw_fetchwait", 1'b0, 1'b0, f_fetch(1'b0));
    cyc("sw_fetch_last", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("sw_dec",  1'b1, 1'b0, f_dec());
    cyc("sw_exec", 1'b1, 1'b0, f_exec(2'd2, 3'd0, 1'b0));
    cyc("sw_mem",  1'b1, 1'b0, f_mem(1'b1));

    // fetch timeout: pulse on the 16th waiting cycle, then fresh fetch
    for (int i = 0; i < 15; i++) cyc("to_fetchwait", 1'b0, 1'b0, f_fetch(1'b0));
    cyc("to_fetch_pulse", 1'b0, 1'b0, with_to(f_fetch(1'b0)));
    cyc("to_fetch_after", 1'b0, 1'b0, f_fetch(1'b0));

    // lw aborted in MEM: no writeback, back to FETCH
    instr = 32'h0000A103;
    cyc("lwto_fetch", 1'b1, 1'b0, f_fetch(1'b1));
    cyc("lwto_dec",   1'b1, 1'b0, f_dec());
    cyc("lwto_exec",  1'b1, 1'b0, f_exec(2'd2, 3'd0, 1'b0));
    for (int i = 0; i < 15; i++) cyc("lwto_memwait", 1'b0, 1'b0, f_mem(1'b0));
    cyc("lwto_pulse", 1'b0, 1'b0, with_to(f_mem(1'b0)));
    cyc("lwto_refetch", 1'b1, 1'b0, f_fetch(1'b1));

    // reset while waiting in MEM
    cyc("rstmid_dec",  1'b1, 1'b0, f_dec());
    cyc("rstmid_exec", 1'b1, 1'b0, f_exec(2'd2, 3'd0, 1'b0));
    cyc("rstmid_mem",  1'b0, 1'b0, f_mem(1'b0));
    rst = 1'b1;
    cyc("rstmid_hold", 1'b0, 1'b0, o(3'd0));
    rst = 1'b0;
    cyc("rstmid_fetch", 1'b1, 1'b0, f_fetch(1'b1));

    // illegal opcode
    instr = 32'hFFFFFFFF;
    cyc("ill_dec", 1'b1, 1'b0, f_dec());
`ifdef ILLEGAL_TRAP_EN
    t = o(3'd7);
    t.trap = 1'b1;
    for (int i = 0; i < 3; i++) cyc("ill_trap", 1'b1, 1'b0, t);
    rst = 1'b1;
    cyc("ill_rst", 1'b1, 1'b0, o(3'd0));
    rst = 1'b0;
    cyc("ill_after", 1'b1, 1'b0, f_fetch(1'b1));
`else
    t = f_fetch(1'b1);
    cyc("ill_nop", 1'b1, 1'b0, t);
    cyc("ill_dec2", 1'b1, 1'b0, f_dec());
    cyc("ill_nop2", 1'b1, 1'b0, t);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
